// File: rtl/rv_dmem_ctrl_if.sv
// Request/response bus between a load/store unit and the data memory controller.
interface rv_dmem_ctrl_if #(
   parameter int Width = 32
);
   logic             req_valid;
   logic             req_ready;
   logic             req_we;
   logic [2:0]       req_funct3;
   logic [Width-1:0] req_addr;
   logic [Width-1:0] req_wdata;
   logic             rsp_valid;
   logic [Width-1:0] rsp_rdata;
   logic             rsp_err;

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/rv_dmem_ctrl.sv
// RISC-V style data memory controller: byte/half/word/double loads and stores
// with a fixed response latency, one outstanding request at a time.
module rv_dmem_ctrl #(
   parameter int Width   = 32,
   parameter int Depth   = 256,
   parameter int Latency = 1
) (
   input  logic          clk,
   input  logic          reset,
   rv_dmem_ctrl_if.slave bus
);

   localparam int L    = Width / 8;
   localparam int OFFW = $clog2(L);
   localparam int IDXW = $clog2(Depth);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   localparam logic [3:0] CNT_INIT = (Latency > 0) ? 4'(Latency - 1) : 4'd0;

   logic [Width-1:0] mem [Depth];

   logic [1:0]       state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic             we_q, we_d;
   logic [2:0]       f3_q, f3_d;
   logic [Width-1:0] addr_q, addr_d;
   logic [Width-1:0] wdata_q, wdata_d;
   logic [Width-1:0] rdata_q, rdata_d;
   logic             err_q, err_d;

   logic             accept;
   logic             enter_resp;
   logic             op_we;
   logic [2:0]       op_f3;
   logic [Width-1:0] op_addr;
   logic [Width-1:0] op_wdata;
   logic [OFFW-1:0]  off;
   logic [IDXW-1:0]  idx;
   logic             illegal;
   logic             misal;
   logic             op_err;
   logic [L-1:0]     be_base;
   logic [L-1:0]     be;
   logic [Width-1:0] wsh;
   logic [Width-1:0] rsh;
   logic             mem_we;
   logic             unused_addr_bits;

   function automatic logic [Width-1:0] load_extend(input logic [Width-1:0] v,
                                                    input logic [2:0] f3);
      logic [Width-1:0] r;
      r = v;
      case (f3[1:0])
         2'd0:    r = f3[2] ? Width'(v[7:0])  : Width'($signed(v[7:0]));
         2'd1:    r = f3[2] ? Width'(v[15:0]) : Width'($signed(v[15:0]));
         2'd2:    r = f3[2] ? Width'(v[31:0]) : Width'($signed(v[31:0]));
         default: r = v;
      endcase
      return r;
   endfunction

   assign accept = bus.req_valid && (state_q == S_IDLE);

   // With Latency=0 the operation completes on the acceptance edge, so the
   // live request fields are used instead of the captured copies.
   assign op_we    = (state_q == S_IDLE) ? bus.req_we     : we_q;
   assign op_f3    = (state_q == S_IDLE) ? bus.req_funct3 : f3_q;
   assign op_addr  = (state_q == S_IDLE) ? bus.req_addr   : addr_q;
   assign op_wdata = (state_q == S_IDLE) ? bus.req_wdata  : wdata_q;

   assign enter_resp = ((state_q == S_IDLE) && accept && (Latency == 0)) ||
                       ((state_q == S_WAIT) && (cnt_q == 4'd0));

   assign off = op_addr[OFFW-1:0];
   assign idx = op_addr[OFFW +: IDXW];
   assign unused_addr_bits = ^op_addr[Width-1:OFFW+IDXW];

   always_comb begin
      illegal = (op_f3 == 3'b111) ||
                ((Width == 32) && ((op_f3 == 3'b011) || (op_f3 == 3'b110)));
      case (op_f3[1:0])
         2'd1:    misal = op_addr[0];
         2'd2:    misal = |op_addr[1:0];
         2'd3:    misal = |op_addr[2:0];
         default: misal = 1'b0;
      endcase
      op_err = illegal || misal;
      case (op_f3[1:0])
         2'd0:    be_base = L'(1);
         2'd1:    be_base = L'(3);
         2'd2:    be_base = L'(15);
         default: be_base = '1;
      endcase
      be  = be_base << off;
      wsh = op_wdata << {off, 3'b000};
      rsh = mem[idx] >> {off, 3'b000};
   end

   assign mem_we = enter_resp && op_we && !op_err && !reset;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      f3_d    = f3_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               we_d    = bus.req_we;
               f3_d    = bus.req_funct3;
               addr_d  = bus.req_addr;
               wdata_d = bus.req_wdata;
               if (Latency == 0) begin
                  state_d = S_RESP;
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = CNT_INIT;
               end
            end
         end
         S_WAIT: begin
            if (cnt_q == 4'd0) state_d = S_RESP;
            else               cnt_d   = cnt_q - 4'd1;
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      // Response registers are nonzero only for the single RESP cycle.
      rdata_d = (enter_resp && !op_we && !op_err) ? load_extend(rsh, op_f3) : '0;
      err_d   = enter_resp && op_err;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   always_ff @(posedge clk) begin
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < L; i++) begin
            if (be[i]) mem[idx][i*8 +: 8] <= wsh[i*8 +: 8];
         end
      end
   end

   assign bus.req_ready = (state_q == S_IDLE);
   assign bus.rsp_valid = (state_q == S_RESP);
   assign bus.rsp_rdata = rdata_q;
   assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_rv_dmem_ctrl.sv
// Scoreboard bench for rv_dmem_ctrl: three instances (Latency 0, 1, 3) share
// one stimulus driver; a negedge monitor pops expected responses per instance.
module tb_rv_dmem_ctrl;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   int          sel = 1;
   logic        drv_valid = 1'b0;
   logic        drv_we = 1'b0;
   logic [2:0]  drv_f3 = 3'b010;
   logic [31:0] drv_addr = '0;
   logic [31:0] drv_wdata = '0;
   logic        ready_sel;
   int          cyc = 0;
   int          total = 0;
   int          bad = 0;
   exp_t        q0[$];
   exp_t        q1[$];
   exp_t        q3[$];

   rv_dmem_ctrl_if #(.Width(32)) i0 ();
   rv_dmem_ctrl_if #(.Width(32)) i1 ();
   rv_dmem_ctrl_if #(.Width(32)) i3 ();

   rv_dmem_ctrl #(.Width(32), .Depth(256), .Latency(0)) u0 (.clk(clk), .reset(reset), .bus(i0.slave));
   rv_dmem_ctrl #(.Width(32), .Depth(256), .Latency(1)) u1 (.clk(clk), .reset(reset), .bus(i1.slave));
   rv_dmem_ctrl #(.Width(32), .Depth(256), .Latency(3)) u3 (.clk(clk), .reset(reset), .bus(i3.slave));

   assign i0.req_valid = drv_valid && (sel == 0);
   assign i1.req_valid = drv_valid && (sel == 1);
   assign i3.req_valid = drv_valid && (sel == 3);
   assign i0.req_we = drv_we;      assign i1.req_we = drv_we;      assign i3.req_we = drv_we;
   assign i0.req_funct3 = drv_f3;  assign i1.req_funct3 = drv_f3;  assign i3.req_funct3 = drv_f3;
   assign i0.req_addr = drv_addr;  assign i1.req_addr = drv_addr;  assign i3.req_addr = drv_addr;
   assign i0.req_wdata = drv_wdata; assign i1.req_wdata = drv_wdata; assign i3.req_wdata = drv_wdata;

   always_comb begin
      ready_sel = i1.req_ready;
      if (sel == 0) ready_sel = i0.req_ready;
      if (sel == 3) ready_sel = i3.req_ready;
   end

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int lat_of(input int id);
      return (id == 0) ? 0 : ((id == 1) ? 1 : 3);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h required %h", nm, act, req);
      end
   endtask

   task automatic check_inst(input int id, input logic v, input logic [31:0] rd, input logic er);
      exp_t e;
      int   qs;
      qs = (id == 0) ? q0.size() : ((id == 1) ? q1.size() : q3.size());
      total++;
      if (v === 1'b1) begin
         if (qs == 0) begin
            bad++;
            $display("FAIL unexpected_rsp inst%0d: got rdata=%h err=%b at cyc %0d required no response",
                     id, rd, er, cyc);
         end else begin
            if (id == 0)      e = q0.pop_front();
            else if (id == 1) e = q1.pop_front();
            else              e = q3.pop_front();
            if (rd !== e.rdata || er !== e.err || cyc != e.cyc) begin
               bad++;
               $display("FAIL rsp inst%0d: got rdata=%h err=%b cyc=%0d required rdata=%h err=%b cyc=%0d",
                        id, rd, er, cyc, e.rdata, e.err, e.cyc);
            end
         end
      end else if (v !== 1'b0 || rd !== 32'h0 || er !== 1'b0) begin
         bad++;
         $display("FAIL idle_outputs inst%0d: got valid=%b rdata=%h err=%b required 0/0/0", id, v, rd, er);
      end
   endtask

   always @(negedge clk) begin
      check_inst(0, i0.rsp_valid, i0.rsp_rdata, i0.rsp_err);
      check_inst(1, i1.rsp_valid, i1.rsp_rdata, i1.rsp_err);
      check_inst(3, i3.rsp_valid, i3.rsp_rdata, i3.rsp_err);
   end

   task automatic send(input int id, input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_er,
                       input bit push);
      exp_t e;
      int   n;
      @(negedge clk);
      sel = id; drv_valid = 1'b1; drv_we = we; drv_f3 = f3; drv_addr = a; drv_wdata = wd;
      n = 0;
      while (ready_sel !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("ready_before_accept", {31'b0, ready_sel}, 32'd1);
      @(posedge clk);
      #1;
      drv_valid = 1'b0;
      if (push) begin
         e.rdata = exp_rd; e.err = exp_er; e.cyc = cyc + lat_of(id);
         if (id == 0)      q0.push_back(e);
         else if (id == 1) q1.push_back(e);
         else              q3.push_back(e);
      end
      chk("ready_after_accept", {31'b0, ready_sel}, 32'd0);
   endtask

   task automatic req(input int id, input logic we, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_er);
      send(id, we, f3, a, wd, exp_rd, exp_er, 1'b1);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((q0.size() + q1.size() + q3.size()) != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("drain_pending", q0.size() + q1.size() + q3.size(), 32'd0);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_ready0", {31'b0, i0.req_ready}, 32'd1);
      chk("reset_ready1", {31'b0, i1.req_ready}, 32'd1);
      chk("reset_ready3", {31'b0, i3.req_ready}, 32'd1);
      chk("reset_valid1", {31'b0, i1.rsp_valid}, 32'd0);
      reset = 1'b0;

      // Latency 1: basic store/load, sub-word loads with extension
      req(1, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
      req(1, 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
      req(1, 1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFFDE, 1'b0);
      req(1, 1'b0, 3'b100, 32'h13, 32'h0, 32'h000000DE, 1'b0);
      req(1, 1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFFDEAD, 1'b0);
      req(1, 1'b0, 3'b101, 32'h12, 32'h0, 32'h0000DEAD, 1'b0);
      req(1, 1'b0, 3'b000, 32'h10, 32'h0, 32'hFFFFFFEF, 1'b0);
      req(1, 1'b0, 3'b001, 32'h10, 32'h0, 32'hFFFFBEEF, 1'b0);
      req(1, 1'b1, 3'b000, 32'h11, 32'hFFFFFF55, 32'h0, 1'b0);
      req(1, 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD55EF, 1'b0);
      // misaligned and illegal sizes
      req(1, 1'b0, 3'b001, 32'h11, 32'h0, 32'h0, 1'b1);
      req(1, 1'b1, 3'b010, 32'h12, 32'hFFFFFFFF, 32'h0, 1'b1);
      req(1, 1'b0, 3'b111, 32'h10, 32'h0, 32'h0, 1'b1);
      req(1, 1'b1, 3'b011, 32'h10, 32'h00000000, 32'h0, 1'b1);
      req(1, 1'b0, 3'b110, 32'h10, 32'h0, 32'h0, 1'b1);
      req(1, 1'b1, 3'b111, 32'h10, 32'h0, 32'h0, 1'b1);
      req(1, 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD55EF, 1'b0);
      // halfword store into the upper lanes
      req(1, 1'b1, 3'b010, 32'h14, 32'h00000000, 32'h0, 1'b0);
      req(1, 1'b1, 3'b001, 32'h16, 32'h9999ABCD, 32'h0, 1'b0);
      req(1, 1'b0, 3'b010, 32'h14, 32'h0, 32'hABCD0000, 1'b0);
      req(1, 1'b0, 3'b001, 32'h16, 32'h0, 32'hFFFFABCD, 1'b0);
      req(1, 1'b0, 3'b100, 32'h15, 32'h0, 32'h00000000, 1'b0);
      // address wrap modulo 1 KiB
      req(1, 1'b1, 3'b010, 32'h400, 32'hA5A5A5A5, 32'h0, 1'b0);
      req(1, 1'b0, 3'b010, 32'h0, 32'h0, 32'hA5A5A5A5, 1'b0);
      req(1, 1'b0, 3'b010, 32'h80000000, 32'h0, 32'hA5A5A5A5, 1'b0);
      drain();

      // reset wins over a simultaneous request
      @(negedge clk);
      sel = 1; drv_valid = 1'b1; drv_we = 1'b1; drv_f3 = 3'b010; drv_addr = 32'h0; drv_wdata = 32'h11111111;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0; drv_valid = 1'b0;
      chk("ready_after_reset_req", {31'b0, i1.req_ready}, 32'd1);
      repeat (4) @(negedge clk);
      req(1, 1'b0, 3'b010, 32'h0, 32'h0, 32'hA5A5A5A5, 1'b0);
      drain();

      // Latency 0
      req(0, 1'b1, 3'b010, 32'h8, 32'hCAFEF00D, 32'h0, 1'b0);
      req(0, 1'b0, 3'b010, 32'h8, 32'h0, 32'hCAFEF00D, 1'b0);
      req(0, 1'b0, 3'b100, 32'h9, 32'h0, 32'h000000F0, 1'b0);
      req(0, 1'b0, 3'b000, 32'h9, 32'h0, 32'hFFFFFFF0, 1'b0);
      req(0, 1'b0, 3'b001, 32'hA, 32'h0, 32'hFFFFCAFE, 1'b0);
      drain();

      // Latency 3: reset in the second WAIT cycle aborts the store
      req(3, 1'b1, 3'b010, 32'h20, 32'h0BADF00D, 32'h0, 1'b0);
      req(3, 1'b0, 3'b010, 32'h20, 32'h0, 32'h0BADF00D, 1'b0);
      drain();
      send(3, 1'b1, 3'b010, 32'h20, 32'h12345678, 32'h0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      chk("ready_after_abort", {31'b0, i3.req_ready}, 32'd1);
      repeat (6) @(negedge clk);
      req(3, 1'b0, 3'b010, 32'h20, 32'h0, 32'h0BADF00D, 1'b0);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no completion required completion");
      $fatal(1, "timeout");
   end

endmodule
